// File: rtl/hilo_unit_pkg.sv
// Shared HI/LO unit encodings: operation codes, data width and the HI/LO pair payload.
package hilo_unit_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

  function automatic logic op_valid(input logic [2:0] op);
    return (op != OP_NONE) && (op <= OP_MTLO);
  endfunction

endpackage

// File: rtl/hilo_div_core.sv
// Unsigned 32-step restoring divider; one quotient bit per cycle after start.
module hilo_div_core
  import hilo_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem,
  output logic              done_c
);

  localparam int unsigned STEP_W = 5;

  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dsr;
  logic [DATA_W-1:0] rem_r;
  logic [STEP_W-1:0] step;
  logic              active;
  logic [DATA_W:0]   rem_sh_c;
  logic              ge_c;

  // Dividend bits leave the top of dvd while quotient bits enter at the bottom.
  assign rem_sh_c = {rem_r, dvd[DATA_W-1]};
  assign ge_c     = rem_sh_c >= {1'b0, dsr};
  assign done_c   = active && (step == STEP_W'(DATA_W - 1));
  assign quot     = dvd;
  assign rem      = rem_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd    <= '0;
      dsr    <= '0;
      rem_r  <= '0;
      step   <= '0;
      active <= 1'b0;
    end else if (start) begin
      dvd    <= dividend;
      dsr    <= divisor;
      rem_r  <= '0;
      step   <= '0;
      active <= 1'b1;
    end else if (active) begin
      rem_r <= ge_c ? DATA_W'(rem_sh_c - {1'b0, dsr}) : rem_sh_c[DATA_W-1:0];
      dvd   <= {dvd[DATA_W-2:0], ge_c};
      step  <= step + STEP_W'(1);
      if (done_c) active <= 1'b0;
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit: MTHI/MTLO, fixed-latency MULT/MULTU and iterative DIV/DIVU.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        HILOop,
  input  logic              HILOwe,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic              Busy
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DIV_FIX} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  hilo_t             prod, prod_n, prod_c;
  logic [DATA_W-1:0] hi_n, lo_n, a_save, a_save_n;
  logic              busy_n, q_neg, q_neg_n, r_neg, r_neg_n, dz, dz_n;
  logic              start_c, div_start_c, div_signed_c;
  logic [DATA_W-1:0] dvd_abs_c, dsr_abs_c, quot, rem;
  logic              div_done_c;

  assign start_c      = HILOwe && !Busy && op_valid(HILOop);
  assign div_start_c  = start_c && ((HILOop == OP_DIV) || (HILOop == OP_DIVU));
  assign div_signed_c = (HILOop == OP_DIV);
  assign dvd_abs_c    = (div_signed_c && A[DATA_W-1]) ? -A : A;
  assign dsr_abs_c    = (div_signed_c && B[DATA_W-1]) ? -B : B;

  // Low 64 bits of a product of extended operands give the exact signed/unsigned result.
  always_comb begin
    if (HILOop == OP_MULT)
      prod_c = {{DATA_W{A[DATA_W-1]}}, A} * {{DATA_W{B[DATA_W-1]}}, B};
    else
      prod_c = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};
  end

  hilo_div_core u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_c),
    .dividend (dvd_abs_c),
    .divisor  (dsr_abs_c),
    .quot     (quot),
    .rem      (rem),
    .done_c   (div_done_c)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    prod_n   = prod;
    hi_n     = HI;
    lo_n     = LO;
    busy_n   = Busy;
    q_neg_n  = q_neg;
    r_neg_n  = r_neg;
    dz_n     = dz;
    a_save_n = a_save;
    case (state)
      IDLE: begin
        if (start_c) begin
          case (HILOop)
            OP_MTHI: hi_n = A;
            OP_MTLO: lo_n = A;
            OP_MULT, OP_MULTU: begin
              if (MUL_LAT == 1) begin
                hi_n = prod_c.hi;
                lo_n = prod_c.lo;
              end else begin
                prod_n  = prod_c;
                cnt_n   = CNT_W'(MUL_LAT - 1);
                busy_n  = 1'b1;
                state_n = MUL;
              end
            end
            OP_DIV, OP_DIVU: begin
              q_neg_n  = div_signed_c && (A[DATA_W-1] ^ B[DATA_W-1]);
              r_neg_n  = div_signed_c && A[DATA_W-1];
              dz_n     = (B == '0);
              a_save_n = A;
              busy_n   = 1'b1;
              state_n  = DIV;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        if (cnt == '0) begin
          hi_n    = prod.hi;
          lo_n    = prod.lo;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      DIV: if (div_done_c) state_n = DIV_FIX;
      DIV_FIX: begin
        // Divide by zero returns the raw dividend in HI and all ones in LO.
        if (dz) begin
          hi_n = a_save;
          lo_n = '1;
        end else begin
          hi_n = r_neg ? -rem : rem;
          lo_n = q_neg ? -quot : quot;
        end
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      prod   <= '0;
      HI     <= '0;
      LO     <= '0;
      Busy   <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      dz     <= 1'b0;
      a_save <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      prod   <= prod_n;
      HI     <= hi_n;
      LO     <= lo_n;
      Busy   <= busy_n;
      q_neg  <= q_neg_n;
      r_neg  <= r_neg_n;
      dz     <= dz_n;
      a_save <= a_save_n;
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: expected HI/LO/latency queued at issue, checked at completion.
module tb_hilo_unit;
  import hilo_unit_pkg::*;

  localparam int unsigned MUL_LAT = 4;
  localparam int DIV_LAT = 33;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  HILOop;
  logic        HILOwe;
  logic [31:0] A, B, HI, LO;
  logic        Busy;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  hilo_unit #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .HILOop(HILOop), .HILOwe(HILOwe),
    .A(A), .B(B), .HI(HI), .LO(LO), .Busy(Busy)
  );

  always #5 clk = ~clk;

  function automatic hilo_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    hilo_t r;
    logic signed [63:0] sp;
    int sa, sb_i;
    r = '0;
    case (op)
      OP_MULT: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        r = sp;
      end
      OP_MULTU: r = {32'h0, a} * {32'h0, b};
      OP_DIVU: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin r.hi = a % b; r.lo = a / b; end
      end
      OP_DIV: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          sa = $signed(a); sb_i = $signed(b);
          r.hi = 32'(sa % sb_i);
          r.lo = 32'(sa / sb_i);
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [2:0] op);
    if (op == OP_MULT || op == OP_MULTU) return int'(MUL_LAT);
    if (op == OP_DIV || op == OP_DIVU) return DIV_LAT;
    return 0;
  endfunction

  // Called at a negedge; the start edge is the following posedge.
  task automatic go(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    HILOop = op; HILOwe = 1'b1; A = a; B = b;
    @(negedge clk);
    HILOwe = 1'b0; HILOop = OP_NONE;
  endtask

  task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int lat);
    exp_t e;
    e.hi = hi; e.lo = lo; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (Busy !== 1'b0 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; HILOwe = 1'b0; HILOop = OP_NONE; A = '0; B = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++; if (HI !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=%h", HI, 32'h0); end
    total++; if (LO !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=%h", LO, 32'h0); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", Busy); end
  endtask

  task automatic run_table(input string name, input logic [2:0] ops[], input logic [31:0] as[],
                           input logic [31:0] bs[], input logic [31:0] ehi[], input logic [31:0] elo[]);
    int cyc;
    exp_t e;
    for (int i = 0; i < ops.size(); i++) begin
      push(ehi[i], elo[i], lat_of(ops[i]));
      go(ops[i], as[i], bs[i]);
      wait_idle(cyc);
      e = sb.pop_front();
      total++; if (HI !== e.hi) begin bad++; $display("FAIL %s[%0d]_hi got=%h exp=%h", name, i, HI, e.hi); end
      total++; if (LO !== e.lo) begin bad++; $display("FAIL %s[%0d]_lo got=%h exp=%h", name, i, LO, e.lo); end
      total++; if (cyc !== e.lat) begin bad++; $display("FAIL %s[%0d]_busy_cycles got=%0d exp=%0d", name, i, cyc, e.lat); end
    end
  endtask

  task automatic test_mthi_mtlo;
    run_table("move",
      '{OP_MTHI, OP_MTLO, OP_NONE, 3'd7},
      '{32'h1234_5678, 32'd5, 32'd77, 32'd88},
      '{32'd0, 32'd0, 32'd0, 32'd0},
      '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678},
      '{32'h0, 32'd5, 32'd5, 32'd5});
  endtask

  task automatic test_mult;
    run_table("mult",
      '{OP_MULT, OP_MULTU, OP_MULT},
      '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h8000_0000},
      '{32'd3, 32'd3, 32'h8000_0000},
      '{32'hFFFF_FFFF, 32'd2, 32'h4000_0000},
      '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'h0});
  endtask

  task automatic test_div;
    run_table("div",
      '{OP_DIV, OP_DIVU, OP_DIV, OP_DIVU, OP_DIV, OP_DIV},
      '{32'hFFFF_FFF9, 32'd100, 32'd7, 32'd42, 32'hFFFF_FFF9, 32'h8000_0000},
      '{32'd2, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'hFFFF_FFFF},
      '{32'hFFFF_FFFF, 32'd2, 32'd1, 32'd42, 32'hFFFF_FFF9, 32'h0},
      '{32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000});
  endtask

  task automatic test_busy_ignore;
    int cyc, hold_bad;
    logic [31:0] old_hi, old_lo;
    exp_t e;
    old_hi = HI; old_lo = LO; hold_bad = 0;
    push(32'd2, 32'hFFFF_FFF2, DIV_LAT);
    go(OP_DIV, 32'd100, 32'hFFFF_FFF9);
    cyc = 0;
    while (Busy !== 1'b0 && cyc < 100) begin
      cyc++;
      if (HI !== old_hi || LO !== old_lo) hold_bad++;
      if (cyc == 10) begin HILOwe = 1'b1; HILOop = OP_MTHI; A = 32'd9; end
      if (cyc == 11) begin HILOwe = 1'b0; HILOop = OP_NONE; end
      @(negedge clk);
    end
    e = sb.pop_front();
    total++; if (hold_bad !== 0) begin bad++; $display("FAIL busy_hold changed_cycles=%0d exp=0", hold_bad); end
    total++; if (HI !== e.hi) begin bad++; $display("FAIL busy_ignore_hi got=%h exp=%h", HI, e.hi); end
    total++; if (LO !== e.lo) begin bad++; $display("FAIL busy_ignore_lo got=%h exp=%h", LO, e.lo); end
    total++; if (cyc !== e.lat) begin bad++; $display("FAIL busy_ignore_cycles got=%0d exp=%0d", cyc, e.lat); end
  endtask

  task automatic test_reset_abort;
    int cyc;
    exp_t e;
    go(OP_MULT, 32'd3, 32'd5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (HI !== 32'h0) begin bad++; $display("FAIL abort_hi got=%h exp=0", HI); end
    total++; if (LO !== 32'h0) begin bad++; $display("FAIL abort_lo got=%h exp=0", LO); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", Busy); end
    push(32'h0, 32'd1, 0);
    go(OP_MTLO, 32'd1, 32'd0);
    wait_idle(cyc);
    e = sb.pop_front();
    total++; if (LO !== e.lo || cyc !== e.lat) begin bad++; $display("FAIL abort_mtlo got lo=%h cyc=%0d exp lo=%h cyc=%0d", LO, cyc, e.lo, e.lat); end
    repeat (6) @(negedge clk);
    total++; if (HI !== e.hi || LO !== e.lo) begin bad++; $display("FAIL abort_no_late_write got hi=%h lo=%h exp hi=%h lo=%h", HI, LO, e.hi, e.lo); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    exp_t e;
    hilo_t m;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0: op = OP_MULT;
        1: op = OP_MULTU;
        2: op = OP_DIV;
        default: op = OP_DIVU;
      endcase
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 50);
        2: b = 32'd0 - 32'($urandom_range(1, 50));
        default: b = $urandom;
      endcase
      m = model(op, a, b);
      push(m.hi, m.lo, lat_of(op));
      go(op, a, b);
      wait_idle(cyc);
      e = sb.pop_front();
      total++; if (HI !== e.hi || LO !== e.lo) begin
        bad++; $display("FAIL b2b[%0d] op=%0d a=%h b=%h got hi=%h lo=%h exp hi=%h lo=%h", i, op, a, b, HI, LO, e.hi, e.lo);
      end
      total++; if (cyc !== e.lat) begin bad++; $display("FAIL b2b[%0d]_cycles got=%0d exp=%0d", i, cyc, e.lat); end
    end
  endtask

  initial begin
    test_reset;
    test_mthi_mtlo;
    test_mult;
    test_div;
    test_busy_ignore;
    test_reset_abort;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
